// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/logic, iterative shifter
// and shift-add multiplier behind a start/busy/done handshake with registered outputs.
module alu_mc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [4:0]       inst,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] flagreg,
    output logic             busy,
    output logic             done
);

    localparam int unsigned M = WIDTH - 1;
    localparam logic [SHW:0] CntOne = (SHW + 1)'(1);
    localparam logic [SHW:0] CntMul = (SHW + 1)'(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

    state_e             state;
    logic [WIDTH-1:0]   sh_q;
    logic [SHW:0]       cnt;
    logic               op_right;
    logic               op_signed;
    logic               mul_neg;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    // Flags live in the low five bits; truncation keeps narrow builds legal.
    function automatic logic [WIDTH-1:0] pack_flags(input logic c, input logic l,
                                                    input logic o, input logic z,
                                                    input logic n);
        logic [WIDTH+4:0] ext;
        ext = {{WIDTH{1'b0}}, n, z, o, l, c};
        return ext[WIDTH-1:0];
    endfunction

    // Single-cycle datapath, evaluated on the accept edge
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_flags;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             sc_c, sc_l, sc_o, sc_z, sc_n;

    assign b_eff   = inst[4] ? ~reg2 : reg2;
    assign sum_ext = {1'b0, reg1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, inst[4]};
    assign mag1    = (inst[3] && reg1[M]) ? -reg1 : reg1;
    assign mag2    = (inst[3] && reg2[M]) ? -reg2 : reg2;

    always_comb begin
        sc_result = '0;
        sc_c = 1'b0;
        sc_l = 1'b0;
        sc_o = 1'b0;
        sc_z = 1'b0;
        sc_n = 1'b0;
        case (inst[2:0])
            3'b000: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_z = (sum_ext[WIDTH-1:0] == '0);
                if (inst[3]) begin
                    sc_o = (reg1[M] == b_eff[M]) && (sum_ext[M] != reg1[M]);
                    sc_n = sum_ext[M];
                end else begin
                    // Carry-out inverted on subtract gives borrow
                    sc_c = inst[4] ? ~sum_ext[WIDTH] : sum_ext[WIDTH];
                    sc_l = (reg2 < reg1);
                end
            end
            3'b001: begin
                sc_result = reg1 & reg2;
                sc_z = ((reg1 & reg2) == '0);
            end
            3'b010: begin
                sc_result = reg1 | reg2;
                sc_z = ((reg1 | reg2) == '0);
            end
            3'b011: begin
                sc_result = reg1 ^ reg2;
                sc_z = ((reg1 ^ reg2) == '0);
            end
            3'b100: begin
                sc_result = reg1;
                sc_z = (reg1 == '0);
                sc_n = inst[3] & reg1[M];
            end
            default: ;
        endcase
        sc_flags = pack_flags(sc_c, sc_l, sc_o, sc_z, sc_n);
    end

    // Shifter step
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [WIDTH-1:0] sh_flags;

    assign sh_next  = op_right ? {op_signed & sh_q[M], sh_q[WIDTH-1:1]}
                               : {sh_q[WIDTH-2:0], 1'b0};
    assign sh_out   = op_right ? sh_q[0] : sh_q[M];
    assign sh_flags = pack_flags(sh_out, 1'b0, 1'b0, (sh_next == '0), op_signed & sh_next[M]);

    // Multiplier step: {hi, lo} with multiplier bits consumed from lo[0]
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;
    logic [WIDTH-1:0]   mul_flags;

    assign hi_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
    assign prod_next = {hi_sum, prod[WIDTH-1:1]};
    assign prod_fix  = mul_neg ? -prod_next : prod_next;
    assign prod_hi   = prod_fix[2*WIDTH-1:WIDTH];
    assign prod_lo   = prod_fix[WIDTH-1:0];
    assign mul_flags = pack_flags(~op_signed & (prod_hi != '0), 1'b0,
                                  op_signed & (prod_hi != {WIDTH{prod_lo[M]}}),
                                  (prod_lo == '0), op_signed & prod_lo[M]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            result    <= '0;
            flagreg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sh_q      <= '0;
            cnt       <= '0;
            op_right  <= 1'b0;
            op_signed <= 1'b0;
            mul_neg   <= 1'b0;
            mcand     <= '0;
            prod      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        if (inst[2:0] == 3'b100 && reg2[SHW-1:0] != '0) begin
                            state     <= StShift;
                            busy      <= 1'b1;
                            sh_q      <= reg1;
                            cnt       <= {1'b0, reg2[SHW-1:0]};
                            op_right  <= inst[4];
                            op_signed <= inst[3];
                        end else if (inst[2:0] == 3'b101) begin
                            state     <= StMul;
                            busy      <= 1'b1;
                            cnt       <= CntMul;
                            mcand     <= mag1;
                            prod      <= {{WIDTH{1'b0}}, mag2};
                            op_signed <= inst[3];
                            mul_neg   <= inst[3] & (reg1[M] ^ reg2[M]);
                        end else begin
                            result  <= sc_result;
                            flagreg <= sc_flags;
                            done    <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    sh_q <= sh_next;
                    cnt  <= cnt - CntOne;
                    if (cnt == CntOne) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= sh_next;
                        flagreg <= sh_flags;
                    end
                end
                StMul: begin
                    prod <= prod_next;
                    cnt  <= cnt - CntOne;
                    if (cnt == CntOne) begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= prod_lo;
                        flagreg <= mul_flags;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table for single-cycle ops, hand sequences
// for shifter/multiplier latency, ignored starts, back-to-back issue and async reset.
module tb_alu_mc;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic [4:0]  inst;
    logic [15:0] result;
    logic [15:0] flagreg;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_mc #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .reg1    (reg1),
        .reg2    (reg2),
        .inst    (inst),
        .result  (result),
        .flagreg (flagreg),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  in;
        logic [15:0] res;
        logic [15:0] flg;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op; returns edges-after-accept until done and busy cycles seen before it.
    // pulse_at >= 0 drives a stray AND request (with scrambled operands) at that point.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [4:0] in,
                         input int pulse_at, output int lat, output int busy_n,
                         output logic busy_at_done);
        @(negedge clk);
        reg1 = a;
        reg2 = b;
        inst = in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            if (lat == pulse_at) begin
                start = 1'b1;
                inst = 5'b00001;
                reg1 = 16'hFFFF;
                reg2 = 16'hFFFF;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        busy_at_done = busy;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] in, input logic [15:0] exp_res,
                          input logic [15:0] exp_flg, input int exp_lat);
        int   lat;
        int   bn;
        logic bd;
        issue(a, b, in, -1, lat, bn, bd);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, bn, exp_lat);
        check({name, " busy at done"}, {31'd0, bd}, 32'd0);
        check({name, " result"}, {16'd0, result}, {16'd0, exp_res});
        check({name, " flags"}, {16'd0, flagreg}, {16'd0, exp_flg});
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   lat;
        int   bn;
        logic bd;
        int   extra;

        // flags: bit0 C, bit1 L, bit2 O, bit3 Z, bit4 N
        vecs[0]  = '{"sadd ovf",      16'h7FFF, 16'h0001, 5'b01000, 16'h8000, 16'h0014};
        vecs[1]  = '{"usub borrow",   16'h0003, 16'h0005, 5'b10000, 16'hFFFE, 16'h0001};
        vecs[2]  = '{"usub equal",    16'h1234, 16'h1234, 5'b10000, 16'h0000, 16'h0008};
        vecs[3]  = '{"uadd carry",    16'hFFFF, 16'h0001, 5'b00000, 16'h0000, 16'h000B};
        vecs[4]  = '{"uadd less",     16'h0005, 16'h0003, 5'b00000, 16'h0008, 16'h0002};
        vecs[5]  = '{"ssub ovf",      16'h8000, 16'h0001, 5'b11000, 16'h7FFF, 16'h0004};
        vecs[6]  = '{"and zero",      16'hF0F0, 16'h0F0F, 5'b00001, 16'h0000, 16'h0008};
        vecs[7]  = '{"or",            16'h1200, 16'h0034, 5'b00010, 16'h1234, 16'h0000};
        vecs[8]  = '{"xor zero",      16'hAAAA, 16'hAAAA, 5'b01011, 16'h0000, 16'h0008};
        vecs[9]  = '{"illegal 110",   16'h1234, 16'h1234, 5'b00110, 16'h0000, 16'h0000};
        vecs[10] = '{"illegal 111",   16'hFFFF, 16'h0001, 5'b11111, 16'h0000, 16'h0000};
        vecs[11] = '{"sra n0",        16'h8001, 16'h0000, 5'b11100, 16'h8001, 16'h0010};
        vecs[12] = '{"shl n0 hibits", 16'h0001, 16'h0010, 5'b00100, 16'h0001, 16'h0000};

        reset_n = 1'b0;
        start = 1'b0;
        reg1 = 16'h0;
        reg2 = 16'h0;
        inst = 5'h0;
        #12;
        check("reset result", {16'd0, result}, 32'd0);
        check("reset flags", {16'd0, flagreg}, 32'd0);
        check("reset busy/done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].in, vecs[i].res, vecs[i].flg, 0);
        end

        run_op("sra 3",   16'h8001, 16'h0003, 5'b11100, 16'hF000, 16'h0010, 3);
        run_op("shl 1",   16'h8001, 16'h0001, 5'b00100, 16'h0002, 16'h0001, 1);
        run_op("srl 2",   16'h0003, 16'h0002, 5'b10100, 16'h0000, 16'h0009, 2);
        run_op("smul",    16'hFFFD, 16'h0005, 5'b01101, 16'hFFF1, 16'h0010, 16);
        run_op("smul ovf", 16'h0100, 16'h0100, 5'b01101, 16'h0000, 16'h000C, 16);
        run_op("smul min", 16'h8000, 16'hFFFF, 5'b01101, 16'h8000, 16'h0014, 16);

        // Unsigned multiply with an AND request pulsed while busy
        issue(16'h0100, 16'h0100, 5'b00101, 5, lat, bn, bd);
        check("umul latency", lat, 16);
        check("umul busy cycles", bn, 16);
        check("umul result", {16'd0, result}, 32'd0);
        check("umul flags", {16'd0, flagreg}, 32'h0009);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("umul no extra done", extra, 0);

        // New op issued in the completion cycle of a shift
        issue(16'h0001, 16'h0001, 5'b00100, -1, lat, bn, bd);
        check("shl chain result", {16'd0, result}, 32'h0002);
        issue(16'h0010, 16'h0020, 5'b00000, -1, lat, bn, bd);
        check("start at done latency", lat, 0);
        check("start at done result", {16'd0, result}, 32'h0030);

        // Back-to-back single-cycle ops with start held
        @(negedge clk);
        reg1 = 16'h00FF;
        reg2 = 16'h0F0F;
        inst = 5'b00001;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b first", {15'd0, done, result}, {15'd0, 1'b1, 16'h000F});
        reg1 = 16'h2222;
        reg2 = 16'h1111;
        inst = 5'b00000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second", {15'd0, done, result}, {15'd0, 1'b1, 16'h3333});
        check("b2b second flags", {16'd0, flagreg}, 32'h0002);
        @(posedge clk);
        #1;
        check("b2b done drop", {31'd0, done}, 32'd0);

        // Async reset five cycles into a multiply
        @(negedge clk);
        reg1 = 16'h0003;
        reg2 = 16'h0007;
        inst = 5'b00101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset result", {16'd0, result}, 32'd0);
        check("async reset flags", {16'd0, flagreg}, 32'd0);
        check("async reset busy/done", {30'd0, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("aborted mul silent", extra, 0);
        run_op("post-reset add", 16'h0003, 16'h0002, 5'b00000, 16'h0005, 16'h0002, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
